// File: rtl/baggage_drop_sequencer_if.sv
// baggage_drop_sequencer_if: height samples and request in, flap control and status out
interface baggage_drop_sequencer_if;
    logic [7:0] height;
    logic       height_valid;
    logic       drop_req;
    logic       drop_en;
    logic       busy;
    logic       done;
    logic       reject;
    logic [7:0] meas_height;
    modport master (
        output height, height_valid, drop_req,
        input  drop_en, busy, done, reject, meas_height
    );
    modport slave (
        input  height, height_valid, drop_req,
        output drop_en, busy, done, reject, meas_height
    );
endinterface

// File: rtl/baggage_drop_sequencer.sv
// baggage_drop_sequencer: settles a height estimate, then opens the flap for a height-scaled time or rejects
module baggage_drop_sequencer #(
    parameter int HOLD        = 4,
    parameter int TOL         = 2,
    parameter int MAX_HEIGHT  = 200,
    parameter int OPEN_BASE   = 8,
    parameter int COOL_CYCLES = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic clk,
    input  logic rst,
    baggage_drop_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(COOL_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, MEASURE, OPEN, COOL, REJECT} state_t;
    state_t state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [8:0]    ocnt, ocnt_n;
    logic [CW-1:0] ccnt, ccnt_n;
    logic [7:0]    ref_h, ref_n, meas, meas_n;
    logic          ref_valid, rv_n;
    logic [8:0]    diff, adiff;
    logic          in_tol;
    logic          drop_en_q, busy_q, done_q, reject_q;
    assign diff   = {1'b0, bus.height} - {1'b0, ref_h};
    assign adiff  = diff[8] ? -diff : diff;
    assign in_tol = adiff <= 9'(TOL);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        ocnt_n  = ocnt;
        ccnt_n  = ccnt;
        ref_n   = ref_h;
        rv_n    = ref_valid;
        meas_n  = meas;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                tcnt_n  = '0;
                rv_n    = 1'b0;
                state_n = bus.drop_req ? MEASURE : IDLE;
            end
            MEASURE: begin
                tcnt_n = tcnt + 1'b1;
                if (bus.height_valid) begin
                    if (ref_valid && in_tol) begin
                        cnt_n = cnt + 1'b1;
                    end else begin
                        ref_n = bus.height;
                        cnt_n = 4'd1;
                        rv_n  = 1'b1;
                    end
                end
                if (bus.height_valid && cnt_n == 4'(HOLD)) begin
                    meas_n  = ref_n;
                    ocnt_n  = {1'b0, ref_n} + 9'(OPEN_BASE);
                    state_n = (ref_n == 8'd0 || {1'b0, ref_n} > 9'(MAX_HEIGHT)) ? REJECT : OPEN;
                end else if (tcnt_n == TW'(TIMEOUT)) begin
                    state_n = REJECT;
                end
            end
            OPEN: begin
                ocnt_n = ocnt - 1'b1;
                if (ocnt == 9'd1) begin
                    state_n = COOL;
                    ccnt_n  = CW'(COOL_CYCLES);
                end
            end
            COOL: begin
                ccnt_n  = ccnt - 1'b1;
                state_n = (ccnt == CW'(1)) ? IDLE : COOL;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            ocnt      <= '0;
            ccnt      <= '0;
            ref_h     <= '0;
            ref_valid <= 1'b0;
            meas      <= '0;
            drop_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tcnt      <= tcnt_n;
            ocnt      <= ocnt_n;
            ccnt      <= ccnt_n;
            ref_h     <= ref_n;
            ref_valid <= rv_n;
            meas      <= meas_n;
            drop_en_q <= state_n == OPEN;
            busy_q    <= state_n != IDLE;
            done_q    <= state_n == COOL && ccnt_n == CW'(1);
            reject_q  <= state_n == REJECT;
        end
    end
    assign bus.drop_en     = drop_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.reject      = reject_q;
    assign bus.meas_height = meas;
endmodule

// File: tb/tb_baggage_drop_sequencer.sv
// tb_baggage_drop_sequencer: randomized and directed checks against a sample-rule model
module tb_baggage_drop_sequencer;
    localparam int HOLD = 4, TOL = 2, MAXH = 200, BASE = 8, COOL = 16, TMO = 255;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    baggage_drop_sequencer_if bus();
    baggage_drop_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0, errors = 0;
    int hv[300];
    int hs[300];
    int sq[$];
    logic r_de[700], r_dn[700], r_rj[700], r_bz[700];
    int exp_meas = 0;
    task automatic load_q(output int n);
        n = sq.size();
        for (int i = 0; i < n; i++) begin
            hv[i] = 1;
            hs[i] = sq[i];
        end
    endtask
    task automatic predict(input int nsamp, output int dk, output int st, output int rv);
        int cnt, r;
        bit have;
        cnt = 0; r = 0; have = 0; dk = TMO; st = 0; rv = 0;
        for (int k = 1; k <= TMO; k++) begin
            if (k <= nsamp && hv[k-1] != 0) begin
                if (!have || hs[k-1] - r > TOL || r - hs[k-1] > TOL) begin
                    r = hs[k-1]; cnt = 1; have = 1;
                end else cnt++;
                if (cnt == HOLD) begin
                    dk = k; st = 1; rv = r;
                    return;
                end
            end
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_meas = 0;
    endtask
    task automatic run(input string name, input int nsamp, input bit hold_req);
        int dk, st, rv, l, end_e, n_de, first_de, n_dn, dn_at, n_rj, rj_at, bz_low;
        bit ok;
        predict(nsamp, dk, st, rv);
        l = rv + BASE;
        ok = st != 0 && rv != 0 && rv <= MAXH;
        end_e = ok ? dk + l + COOL : dk + 1;
        if (st != 0) exp_meas = rv;
        @(negedge clk);
        bus.drop_req = 1'b1;
        bus.height_valid = 1'b0;
        @(posedge clk);
        #1;
        r_bz[0] = bus.busy;
        bus.drop_req = hold_req;
        bus.height_valid = nsamp > 0 && hv[0] != 0;
        bus.height = 8'(hs[0]);
        for (int e = 1; e <= end_e + 2; e++) begin
            @(posedge clk);
            #1;
            r_de[e] = bus.drop_en; r_dn[e] = bus.done; r_rj[e] = bus.reject; r_bz[e] = bus.busy;
            bus.height_valid = e < nsamp && hv[e] != 0;
            bus.height = 8'(hs[e]);
        end
        bus.drop_req = 1'b0;
        bus.height_valid = 1'b0;
        n_de = 0; first_de = -1; n_dn = 0; dn_at = -1; n_rj = 0; rj_at = -1; bz_low = -1;
        for (int e = 1; e <= end_e + 2; e++) begin
            if (r_de[e]) begin n_de++; if (first_de < 0) first_de = e; end
            if (r_dn[e]) begin n_dn++; if (dn_at < 0) dn_at = e; end
            if (r_rj[e]) begin n_rj++; if (rj_at < 0) rj_at = e; end
            if (!r_bz[e] && bz_low < 0) bz_low = e;
        end
        checks++; if (r_bz[0] !== 1'b1) begin errors++; $display("FAIL %s busy_start got %b want 1", name, r_bz[0]); end
        checks++; if (n_de != (ok ? l : 0)) begin errors++; $display("FAIL %s drop_en_cycles got %0d want %0d", name, n_de, ok ? l : 0); end
        checks++; if (n_dn != (ok ? 1 : 0)) begin errors++; $display("FAIL %s done_pulses got %0d want %0d", name, n_dn, ok ? 1 : 0); end
        checks++; if (n_rj != (ok ? 0 : 1)) begin errors++; $display("FAIL %s reject_pulses got %0d want %0d", name, n_rj, ok ? 0 : 1); end
        checks++; if (bz_low != end_e) begin errors++; $display("FAIL %s busy_low_at got %0d want %0d", name, bz_low, end_e); end
        checks++; if (bus.meas_height !== 8'(exp_meas)) begin errors++; $display("FAIL %s meas_height got %0d want %0d", name, bus.meas_height, exp_meas); end
        if (ok) begin
            checks++; if (first_de != dk) begin errors++; $display("FAIL %s drop_en_start got %0d want %0d", name, first_de, dk); end
            checks++; if (dn_at != dk + l + COOL - 1) begin errors++; $display("FAIL %s done_at got %0d want %0d", name, dn_at, dk + l + COOL - 1); end
        end else begin
            checks++; if (rj_at != dk) begin errors++; $display("FAIL %s reject_at got %0d want %0d", name, rj_at, dk); end
        end
        if (hold_req) begin
            checks++; if (r_bz[end_e + 1] !== 1'b1) begin errors++; $display("FAIL %s rearm_busy got %b want 1", name, r_bz[end_e + 1]); end
        end
    endtask
    task automatic test_reset();
        int n;
        bus.drop_req = 1'b1; bus.height_valid = 1'b1; bus.height = 8'd50;
        do_reset();
        bus.drop_req = 1'b0; bus.height_valid = 1'b0;
        checks++;
        if ({bus.drop_en, bus.busy, bus.done, bus.reject} !== 4'b0 || bus.meas_height !== 8'd0) begin
            errors++; $display("FAIL reset outputs got %b/%0d want 0000/0", {bus.drop_en, bus.busy, bus.done, bus.reject}, bus.meas_height);
        end
        n = 0;
    endtask
    task automatic test_directed();
        int n;
        sq = {50, 51, 49, 50};     load_q(n); run("normal", n, 0);
        sq = {50, 60, 60, 61, 59}; load_q(n); run("unsettled", n, 0);
        sq = {201, 201, 201, 201}; load_q(n); run("tall", n, 0);
        sq = {0, 0, 0, 0};         load_q(n); run("empty", n, 0);
        sq = {200, 200, 200, 200}; load_q(n); run("max_ok", n, 0);
        sq = {100, 102, 98, 100};  load_q(n); run("tol_edge", n, 0);
        sq = {100, 103, 101, 104, 102, 102}; load_q(n); run("tol_over", n, 0);
        run("timeout", 0, 0);
    endtask
    task automatic test_ignored_req();
        int n;
        sq = {30, 30, 30, 30};
        load_q(n);
        for (int i = n; i < 60; i++) begin hv[i] = 1; hs[i] = 90; end
        run("hold_req", n, 1);
        do_reset();
    endtask
    task automatic test_reset_mid();
        int n, waited, dn;
        sq = {50, 50, 50, 50};
        load_q(n);
        @(negedge clk);
        bus.drop_req = 1'b1;
        @(posedge clk);
        #1 bus.drop_req = 1'b0;
        waited = 0;
        for (int e = 0; e < 60 && !bus.drop_en; e++) begin
            bus.height_valid = e < n;
            bus.height = 8'(hs[e]);
            @(posedge clk);
            #1 waited++;
        end
        bus.height_valid = 1'b0;
        checks++; if (bus.drop_en !== 1'b1) begin errors++; $display("FAIL rstmid open_reached got %b want 1 after %0d", bus.drop_en, waited); end
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_meas = 0;
        checks++; if ({bus.drop_en, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL rstmid outputs got %b want 000", {bus.drop_en, bus.busy, bus.done}); end
        dn = 0;
        repeat (80) begin @(posedge clk); #1 if (bus.done || bus.reject || bus.drop_en) dn++; end
        checks++; if (dn != 0) begin errors++; $display("FAIL rstmid stray_activity got %0d want 0", dn); end
        checks++; if (bus.meas_height !== 8'd0) begin errors++; $display("FAIL rstmid meas got %0d want 0", bus.meas_height); end
        for (int i = 0; i < 300; i++) hv[i] = 0;
        load_q(n);
        run("fresh", n, 0);
    endtask
    task automatic test_random();
        int base, j, v;
        for (int it = 0; it < 15; it++) begin
            base = int'($urandom_range(0, 225));
            for (int i = 0; i < 300; i++) begin
                j = int'($urandom_range(0, 6)) - 3;
                v = base + j;
                hv[i] = (i < 40 && $urandom_range(0, 3) != 0) ? 1 : 0;
                hs[i] = v < 0 ? 0 : (v > 255 ? 255 : v);
            end
            run("random", 40, 0);
        end
    endtask
    initial begin
        rst = 1'b0;
        bus.drop_req = 1'b0; bus.height_valid = 1'b0; bus.height = 8'd0;
        for (int i = 0; i < 300; i++) begin hv[i] = 0; hs[i] = 0; end
        test_reset();
        test_directed();
        test_ignored_req();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
